// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode values and the
// immediate-format code carried out of the decode stage.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational RV32I immediate decode: picks the format from the
// opcode and assembles the sign-extended immediate for it.
module imm_decode_comb
    import riscv_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm,
    output imm_fmt_e    fmt,
    output logic        illegal
);

    logic [6:0] opc;
    logic       sgn;

    assign opc = inst[6:0];
    assign sgn = inst[31];

    // Opcode to format; anything outside the known list is flagged
    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR,
            OPC_FENCE, OPC_SYSTEM: fmt = FMT_I;
            OPC_STORE:             fmt = FMT_S;
            OPC_BRANCH:            fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:    fmt = FMT_U;
            OPC_JAL:               fmt = FMT_J;
            OPC_OP:                fmt = FMT_R;
            default:               illegal = 1'b1;
        endcase
    end

    // Field scramble per format; U is the only unextended form
    always_comb begin
        imm = 32'h0;
        case (fmt)
            FMT_I: imm = {{20{sgn}}, inst[31:20]};
            FMT_S: imm = {{20{sgn}}, inst[31:25], inst[11:7]};
            FMT_B: imm = {{19{sgn}}, inst[31], inst[7],
                          inst[30:25], inst[11:8], 1'b0};
            FMT_U: imm = {inst[31:12], 12'h000};
            FMT_J: imm = {{11{sgn}}, inst[31], inst[19:12],
                          inst[20], inst[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/immediate_gen.sv
// Registered immediate generator: decode followed by one output
// register bank with stall (en) and async active-high reset.
module immediate_gen
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] input_instruction,
    output logic [31:0] output_instruction,
    output logic [2:0]  imm_fmt,
    output logic        imm_illegal
);

    logic [31:0] imm_d;
    imm_fmt_e    fmt_d;
    logic        illegal_d;

    imm_decode_comb u_dec (
        .inst    (input_instruction),
        .imm     (imm_d),
        .fmt     (fmt_d),
        .illegal (illegal_d)
    );

    // Capture decoded immediate when enabled; reset clears at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_instruction <= 32'h0;
            imm_fmt            <= 3'd0;
            imm_illegal        <= 1'b0;
        end else if (en) begin
            output_instruction <= imm_d;
            imm_fmt            <= fmt_d;
            imm_illegal        <= illegal_d;
        end
    end

endmodule

// File: tb/tb_immediate_gen.sv
// Directed self-checking bench for immediate_gen with
// hand-computed expected immediates and formats.
module tb_immediate_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] input_instruction;
    logic [31:0] output_instruction;
    logic [2:0]  imm_fmt;
    logic        imm_illegal;

    int n_cmp = 0;
    int n_err = 0;

    immediate_gen dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .input_instruction  (input_instruction),
        .output_instruction (output_instruction),
        .imm_fmt            (imm_fmt),
        .imm_illegal        (imm_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] i);
        @(negedge clk);
        input_instruction = i;
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [31:0] imm,
                        input logic [2:0] fmt, input logic ill);
        chk({tag, ".imm"}, output_instruction, imm);
        chk({tag, ".fmt"}, {29'b0, imm_fmt}, {29'b0, fmt});
        chk({tag, ".ill"}, {31'b0, imm_illegal}, {31'b0, ill});
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        input_instruction = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        chk3("reset", 32'h0, 3'd0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        step(32'h0000_0033);
        chk3("r_type", 32'h0, 3'd0, 1'b0);

        step(32'd51);
        chk3("bare51", 32'h0, 3'd0, 1'b0);
        step(32'd3);
        chk3("bare3", 32'h0, 3'd1, 1'b0);
        step(32'd35);
        chk3("bare35", 32'h0, 3'd2, 1'b0);
        step(32'd103);
        chk3("bare103", 32'h0, 3'd1, 1'b0);

        step(32'hFFC1_2083);
        chk3("lw", 32'hFFFF_FFFC, 3'd1, 1'b0);
        step(32'h0051_2423);
        chk3("sw", 32'h0000_0008, 3'd2, 1'b0);
        step(32'hFF9F_F06F);
        chk3("jal", 32'hFFFF_FFF8, 3'd5, 1'b0);
        step(32'h1234_50B7);
        chk3("lui", 32'h1234_5000, 3'd4, 1'b0);
        step(32'h0000_0863);
        chk3("beq", 32'h0000_0010, 3'd3, 1'b0);
        step(32'h8000_0017);
        chk3("auipc", 32'h8000_0000, 3'd4, 1'b0);

        step(32'h0000_007F);
        chk3("illegal", 32'h0, 3'd0, 1'b1);

        @(negedge clk);
        en = 1'b0;
        input_instruction = 32'hFFC1_2083;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk3("stall", 32'h0, 3'd0, 1'b1);
        end

        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk3("unstall", 32'hFFFF_FFFC, 3'd1, 1'b0);

        @(negedge clk);
        en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk3("async_rst", 32'h0, 3'd0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk3("post_rst_hold", 32'h0, 3'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
